perceptron_classifier: RTL and testbench

Inference-side counterpart of the perceptron/Adaline training unit. It consumes the trained weights w1, w2 and bias b, then streams labelled test samples through a valid/ready interface. For each sample it computes yin = w1*x1 + w2*x2 + b using a single shared multiplier over several cycles, and emits the bipolar decision. It counts samples and misclassifications, and pulses done after the sample flagged last.

---
 rtl/perceptron_classifier.sv | 152 +++++++++++++++
 tb/tb_perceptron_classifier.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_classifier.sv
`default_nettype none
// ============================================================================
// Module      : perceptron_classifier
// Description : Streams labelled samples through trained perceptron weights
//               with one shared multiplier; tracks sample and error counts.
// Revision    : 1.0 - initial release
// ============================================================================
module perceptron_classifier #(
  parameter int DW   = 14,
  parameter int FRAC = 0,
  parameter int CW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] w1,
  input  logic [DW-1:0] w2,
  input  logic [DW-1:0] b,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_x1,
  input  logic [DW-1:0] s_x2,
  input  logic          s_t,
  input  logic          s_last,
  output logic          o_valid,
  input  logic          o_ready,
  output logic          o_y,
  output logic [DW-1:0] o_yin,
  output logic [CW-1:0] smp_cnt,
  output logic [CW-1:0] err_cnt,
  output logic          busy,
  output logic          done
);

  localparam int AW = 2*DW + 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_MUL1 = 3'd2,
    S_MUL2 = 3'd3,
    S_ADDB = 3'd4,
    S_OUT  = 3'd5,
    S_FIN  = 3'd6
  } state_t;

  state_t r_state, w_next;

  logic [DW-1:0]        r_w1, r_w2, r_b, r_x1, r_x2;
  logic                 r_t, r_last;
  logic signed [AW-1:0] r_acc;
  logic [CW-1:0]        r_smp, r_err;

  logic [DW-1:0]        w_op_a, w_op_b;
  logic signed [AW-1:0] w_a_ext, w_b_ext, w_prod, w_bias, w_shift;
  logic [AW-DW:0]       w_hi;
  logic [DW-1:0]        w_sat;
  logic                 w_y;

  // Operands are widened to the accumulator width first so the product is exact.
  assign w_op_a  = (r_state == S_MUL1) ? r_w1 : r_w2;
  assign w_op_b  = (r_state == S_MUL1) ? r_x1 : r_x2;
  assign w_a_ext = {{(AW-DW){w_op_a[DW-1]}}, w_op_a};
  assign w_b_ext = {{(AW-DW){w_op_b[DW-1]}}, w_op_b};
  assign w_prod  = w_a_ext * w_b_ext;
  assign w_bias  = $signed({{(AW-DW){r_b[DW-1]}}, r_b}) <<< FRAC;

  assign w_shift = r_acc >>> FRAC;
  assign w_hi    = w_shift[AW-1:DW-1];
  assign w_sat   = ((&w_hi) || !(|w_hi)) ? w_shift[DW-1:0]
                 : (w_hi[AW-DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}});
  assign w_y     = ~r_acc[AW-1];

  assign o_y     = (r_state == S_OUT) && w_y;
  assign o_yin   = (r_state == S_OUT) ? w_sat : '0;
  assign smp_cnt = r_smp;
  assign err_cnt = r_err;

  always_comb begin
    w_next  = r_state;
    s_ready = 1'b0;
    o_valid = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_WAIT;
      end
      S_WAIT: begin
        s_ready = 1'b1;
        if (s_valid) w_next = S_MUL1;
      end
      S_MUL1: w_next = S_MUL2;
      S_MUL2: w_next = S_ADDB;
      S_ADDB: w_next = S_OUT;
      S_OUT: begin
        o_valid = 1'b1;
        if (o_ready) w_next = r_last ? S_FIN : S_WAIT;
      end
      S_FIN: begin
        busy   = 1'b0;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_w1    <= '0;
      r_w2    <= '0;
      r_b     <= '0;
      r_x1    <= '0;
      r_x2    <= '0;
      r_t     <= 1'b0;
      r_last  <= 1'b0;
      r_acc   <= '0;
      r_smp   <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (start) begin
          r_w1  <= w1;
          r_w2  <= w2;
          r_b   <= b;
          r_smp <= '0;
          r_err <= '0;
        end
        S_WAIT: if (s_valid) begin
          r_x1   <= s_x1;
          r_x2   <= s_x2;
          r_t    <= s_t;
          r_last <= s_last;
        end
        S_MUL1: r_acc <= w_prod;
        S_MUL2: r_acc <= r_acc + w_prod;
        S_ADDB: r_acc <= r_acc + w_bias;
        S_OUT: if (o_ready) begin
          if (r_smp != {CW{1'b1}}) r_smp <= r_smp + CW'(1);
          if ((w_y != r_t) && (r_err != {CW{1'b1}})) r_err <= r_err + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_perceptron_classifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_perceptron_classifier
// Description : Randomised self-checking bench against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perceptron_classifier;
  localparam int DW   = 14;
  localparam int FRAC = 0;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rst, start, s_valid, s_ready, s_t, s_last;
  logic          o_valid, o_ready, o_y, busy, done;
  logic [DW-1:0] w1, w2, b, s_x1, s_x2, o_yin;
  logic [CW-1:0] smp_cnt, err_cnt;

  int checks = 0;
  int errors = 0;
  int m_smp, m_err;
  int cw1, cw2, cb;

  perceptron_classifier #(.DW(DW), .FRAC(FRAC), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .w1(w1), .w2(w2), .b(b),
    .s_valid(s_valid), .s_ready(s_ready), .s_x1(s_x1), .s_x2(s_x2),
    .s_t(s_t), .s_last(s_last), .o_valid(o_valid), .o_ready(o_ready),
    .o_y(o_y), .o_yin(o_yin), .smp_cnt(smp_cnt), .err_cnt(err_cnt),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference: exact integer dot product, floor-shifted, then clamped.
  function automatic longint model_raw(int x1, int x2);
    longint acc;
    acc = longint'(cw1) * x1 + longint'(cw2) * x2 + longint'(cb) * (longint'(1) << FRAC);
    return acc >>> FRAC;
  endfunction

  function automatic int model_sat(longint v);
    longint hi, lo;
    hi = (longint'(1) << (DW-1)) - 1;
    lo = -(longint'(1) << (DW-1));
    if (v > hi) return int'(hi);
    if (v < lo) return int'(lo);
    return int'(v);
  endfunction

  function automatic int rnd_s();
    return int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW-1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int a1, input int a2, input int bb);
    cw1 = a1; cw2 = a2; cb = bb;
    w1 = a1[DW-1:0]; w2 = a2[DW-1:0]; b = bb[DW-1:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    m_smp = 0; m_err = 0;
  endtask

  // Presents a sample and waits for acceptance; returns edges from the
  // handshake until o_valid (or -1 if the sample was never accepted).
  task automatic send_wait(input int x1, input int x2, input bit t, input bit last,
                           output int lat);
    int n;
    s_x1 = x1[DW-1:0]; s_x2 = x2[DW-1:0]; s_t = t; s_last = last;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 100) begin tick(); n++; end
    if (!s_ready) begin
      s_valid = 1'b0;
      lat = -1;
    end else begin
      tick();
      s_valid = 1'b0;
      lat = 0;
      while (!o_valid && lat < 100) begin tick(); lat++; end
    end
  endtask

  task automatic accept();
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
  endtask

  task automatic model_count(input int yv, input bit t);
    int lim;
    lim = (1 << CW) - 1;
    if (m_smp < lim) m_smp++;
    if ((yv != 0) != t && m_err < lim) m_err++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; s_valid = 1'b0; o_ready = 1'b0;
    w1 = '0; w2 = '0; b = '0; s_x1 = '0; s_x2 = '0; s_t = 1'b0; s_last = 1'b0;
    tick(); tick();
    checks++;
    if ({s_ready, o_valid, o_y, o_yin, smp_cnt, err_cnt, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b v=%b y=%b yin=%0d smp=%0d err=%0d busy=%b done=%b exp all 0",
               s_ready, o_valid, o_y, o_yin, smp_cnt, err_cnt, busy, done);
    end
    rst = 1'b0; start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored got busy=%b exp 0", busy); end
  endtask

  task automatic test_single();
    int lat, ey, eyin;
    do_start(3, -1, 1);
    checks++;
    if (busy !== 1'b1 || smp_cnt !== '0) begin
      errors++; $display("FAIL single_start got busy=%b smp=%0d exp busy=1 smp=0", busy, smp_cnt);
    end
    send_wait(2, 5, 1'b1, 1'b1, lat);
    eyin = model_sat(model_raw(2, 5)); ey = (eyin >= 0);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL single_latency got %0d exp 3", lat); end
    checks++;
    if (o_y !== ey[0] || $signed(o_yin) !== eyin) begin
      errors++; $display("FAIL single_result got y=%b yin=%0d exp y=%0d yin=%0d", o_y, $signed(o_yin), ey, eyin);
    end
    model_count(ey, 1'b1);
    accept();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || o_valid !== 1'b0) begin
      errors++; $display("FAIL single_done got done=%b busy=%b v=%b exp 1 0 0", done, busy, o_valid);
    end
    checks++;
    if (smp_cnt !== m_smp[CW-1:0] || err_cnt !== m_err[CW-1:0]) begin
      errors++; $display("FAIL single_counts got smp=%0d err=%0d exp %0d %0d", smp_cnt, err_cnt, m_smp, m_err);
    end
    tick();
    checks++;
    if (done !== 1'b0 || smp_cnt !== m_smp[CW-1:0]) begin
      errors++; $display("FAIL single_done_pulse got done=%b smp=%0d exp 0 %0d", done, smp_cnt, m_smp);
    end
  endtask

  // One-sample runs with fixed weights: misclassification and yin == 0.
  task automatic test_edge_values();
    int lat, ey, eyin;
    int tv[4][6] = '{'{3, -1, 1, 0, 4, 1}, '{1, 1, 0, 5, -5, 0},
                     '{3, -1, 1, -7, 2, 0}, '{-2, 4, -1, 3, 1, 1}};
    for (int i = 0; i < 4; i++) begin
      do_start(tv[i][0], tv[i][1], tv[i][2]);
      send_wait(tv[i][3], tv[i][4], tv[i][5][0], 1'b1, lat);
      eyin = model_sat(model_raw(tv[i][3], tv[i][4])); ey = (eyin >= 0);
      checks++;
      if (lat !== 3 || o_y !== ey[0] || $signed(o_yin) !== eyin) begin
        errors++; $display("FAIL edge_%0d got lat=%0d y=%b yin=%0d exp lat=3 y=%0d yin=%0d",
                           i, lat, o_y, $signed(o_yin), ey, eyin);
      end
      model_count(ey, tv[i][5][0]);
      accept();
      checks++;
      if (err_cnt !== m_err[CW-1:0] || smp_cnt !== 16'd1) begin
        errors++; $display("FAIL edge_cnt_%0d got err=%0d smp=%0d exp %0d 1", i, err_cnt, smp_cnt, m_err);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    int lat, ey, eyin;
    int xs[2] = '{8191, -8192};
    do_start(8191, 8191, 8191);
    for (int i = 0; i < 2; i++) begin
      send_wait(xs[i], xs[i], i == 0, i == 1, lat);
      eyin = model_sat(model_raw(xs[i], xs[i])); ey = (eyin >= 0);
      checks++;
      if (lat !== 3 || o_y !== ey[0] || $signed(o_yin) !== eyin) begin
        errors++; $display("FAIL sat_%0d got lat=%0d y=%b yin=%0d exp lat=3 y=%0d yin=%0d",
                           i, lat, o_y, $signed(o_yin), ey, eyin);
      end
      model_count(ey, i == 0);
      accept();
    end
    checks++;
    if (smp_cnt !== 16'd2 || err_cnt !== m_err[CW-1:0] || done !== 1'b1) begin
      errors++; $display("FAIL sat_counts got smp=%0d err=%0d done=%b exp 2 %0d 1", smp_cnt, err_cnt, done, m_err);
    end
    tick();
  endtask

  // Gapped random stream; one sample is stalled and must hold its outputs.
  task automatic test_stream(input int n, input int stall_idx, input bit full_range);
    int lat, ey, eyin, x1, x2, gap;
    bit t, last;
    logic          hy;
    logic [DW-1:0] hyin;
    if (full_range) do_start(rnd_s(), rnd_s(), rnd_s());
    else do_start(int'($urandom_range(0, 40)) - 20, int'($urandom_range(0, 40)) - 20,
                  int'($urandom_range(0, 40)) - 20);
    for (int i = 0; i < n; i++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) tick();
      x1 = full_range ? rnd_s() : int'($urandom_range(0, 200)) - 100;
      x2 = full_range ? rnd_s() : int'($urandom_range(0, 200)) - 100;
      t = 1'($urandom_range(0, 1)); last = (i == n - 1);
      send_wait(x1, x2, t, last, lat);
      eyin = model_sat(model_raw(x1, x2)); ey = (eyin >= 0);
      checks++;
      if (lat !== 3 || o_y !== ey[0] || $signed(o_yin) !== eyin) begin
        errors++; $display("FAIL stream_%0d got lat=%0d y=%b yin=%0d exp lat=3 y=%0d yin=%0d",
                           i, lat, o_y, $signed(o_yin), ey, eyin);
      end
      if (i == stall_idx) begin
        hy = o_y; hyin = o_yin;
        s_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
          tick();
          checks++;
          if (o_valid !== 1'b1 || o_y !== hy || o_yin !== hyin || s_ready !== 1'b0) begin
            errors++; $display("FAIL stall_%0d got v=%b y=%b yin=%0d rdy=%b exp v=1 y=%b yin=%0d rdy=0",
                               s, o_valid, o_y, $signed(o_yin), s_ready, hy, $signed(hyin));
          end
        end
        s_valid = 1'b0;
      end
      model_count(ey, t);
      accept();
      checks++;
      if (smp_cnt !== m_smp[CW-1:0] || err_cnt !== m_err[CW-1:0] || done !== last || o_valid !== 1'b0) begin
        errors++; $display("FAIL stream_cnt_%0d got smp=%0d err=%0d done=%b v=%b exp %0d %0d %b 0",
                           i, smp_cnt, err_cnt, done, o_valid, m_smp, m_err, last);
      end
    end
    tick();
  endtask

  task automatic test_disturb();
    int lat, ey, eyin;
    do_start(5, -3, 7);
    send_wait(4, 6, 1'b0, 1'b0, lat);
    eyin = model_sat(model_raw(4, 6)); ey = (eyin >= 0);
    accept();
    model_count(ey, 1'b0);
    // In MUL1 of the next sample: new weights plus a stray start.
    s_x1 = 14'd9; s_x2 = -14'sd2; s_t = 1'b1; s_last = 1'b1; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    w1 = 14'd100; w2 = 14'd100; b = -14'sd100; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!o_valid && lat < 100) begin tick(); lat++; end
    eyin = model_sat(model_raw(9, -2)); ey = (eyin >= 0);
    checks++;
    if (lat !== 3 || o_y !== ey[0] || $signed(o_yin) !== eyin || busy !== 1'b1) begin
      errors++; $display("FAIL disturb_latched got lat=%0d y=%b yin=%0d busy=%b exp 3 %0d %0d 1",
                         lat, o_y, $signed(o_yin), busy, ey, eyin);
    end
    model_count(ey, 1'b1);
    accept();
    checks++;
    if (smp_cnt !== 16'd2 || err_cnt !== m_err[CW-1:0]) begin
      errors++; $display("FAIL disturb_cnt got smp=%0d err=%0d exp 2 %0d", smp_cnt, err_cnt, m_err);
    end
    tick();
    // Abort in MUL2.
    do_start(2, 2, 2);
    send_wait(1, 1, 1'b1, 1'b0, lat);
    accept();
    s_x1 = 14'd3; s_x2 = 14'd3; s_t = 1'b1; s_last = 1'b1; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({s_ready, o_valid, o_y, o_yin, smp_cnt, err_cnt, busy, done} !== '0) begin
      errors++; $display("FAIL abort_reset got rdy=%b v=%b y=%b yin=%0d smp=%0d err=%0d busy=%b done=%b exp all 0",
                         s_ready, o_valid, o_y, o_yin, smp_cnt, err_cnt, busy, done);
    end
    tick();
    do_start(-4, 1, 0);
    send_wait(3, 2, 1'b0, 1'b1, lat);
    eyin = model_sat(model_raw(3, 2)); ey = (eyin >= 0);
    checks++;
    if (lat !== 3 || o_y !== ey[0] || $signed(o_yin) !== eyin) begin
      errors++; $display("FAIL after_abort got lat=%0d y=%b yin=%0d exp 3 %0d %0d", lat, o_y, $signed(o_yin), ey, eyin);
    end
    model_count(ey, 1'b0);
    accept();
    checks++;
    if (smp_cnt !== 16'd1 || err_cnt !== m_err[CW-1:0] || done !== 1'b1) begin
      errors++; $display("FAIL after_abort_cnt got smp=%0d err=%0d done=%b exp 1 %0d 1", smp_cnt, err_cnt, done, m_err);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_edge_values();
    test_saturation();
    test_stream(4, 1, 1'b0);
    test_stream(6, 3, 1'b1);
    test_stream(5, 0, 1'b1);
    test_disturb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
